// File: rtl/reg_scoreboard_if.sv
// rtl/reg_scoreboard_if.sv - issue/writeback/lookup bundle for the register scoreboard
interface reg_scoreboard_if #(
  parameter int AW   = 5,
  parameter int NREG = 32
);
  logic            iss_valid;
  logic [AW-1:0]   iss_dst;
  logic            iss_ready;
  logic            wb_valid;
  logic [AW-1:0]   wb_dst;
  logic [AW-1:0]   rs1;
  logic [AW-1:0]   rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic [NREG-1:0] wr_onehot;
  logic [NREG-1:0] busy_vec;
  logic [AW:0]     busy_count;
  logic            err_clr_idle;

  modport master (
    output iss_valid, iss_dst, wb_valid, wb_dst, rs1, rs2,
    input  iss_ready, rs1_busy, rs2_busy, wr_onehot, busy_vec, busy_count, err_clr_idle
  );

  modport slave (
    input  iss_valid, iss_dst, wb_valid, wb_dst, rs1, rs2,
    output iss_ready, rs1_busy, rs2_busy, wr_onehot, busy_vec, busy_count, err_clr_idle
  );
endinterface

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy tracking with WAW issue stall and regfile write enables
module reg_scoreboard #(
  parameter int AW       = 5,
  parameter int NREG     = 32,
  parameter int HAS_ZERO = 1,
  parameter int ZERO_REG = 31
) (
  input logic            clk,
  input logic            reset_n,
  reg_scoreboard_if.slave sb
);
  localparam logic [NREG-1:0] ONE   = NREG'(1);
  localparam logic [NREG-1:0] ZMASK = (HAS_ZERO != 0) ? (ONE << ZERO_REG) : '0;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] wr_q;
  logic [AW:0]     count_q;
  logic            err_q;

  logic [NREG-1:0] iss_oh;
  logic [NREG-1:0] wb_oh;
  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;
  logic [NREG-1:0] busy_nxt;
  logic [AW:0]     count_nxt;
  logic            iss_in_z;
  logic            wb_in_z;
  logic            iss_ready;
  logic            iss_fire;
  logic            err_hit;

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = '0;
    for (int i = 0; i < NREG; i++) begin
      c = c + (AW+1)'(v[i]);
    end
    return c;
  endfunction

  always_comb begin
    iss_oh   = ONE << sb.iss_dst;
    wb_oh    = ONE << sb.wb_dst;
    iss_in_z = |(iss_oh & ZMASK);
    wb_in_z  = |(wb_oh & ZMASK);
    clr      = sb.wb_valid ? (wb_oh & ~ZMASK) : '0;
    // A same-cycle writeback to the destination frees it, so issue need not stall.
    iss_ready = iss_in_z | ~busy_q[sb.iss_dst] | clr[sb.iss_dst];
    iss_fire  = sb.iss_valid & iss_ready;
    set       = iss_fire ? (iss_oh & ~ZMASK) : '0;
    busy_nxt  = (busy_q & ~clr) | set;
    count_nxt = popcount(busy_nxt);
    err_hit   = sb.wb_valid & ~wb_in_z & ~busy_q[sb.wb_dst];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy_q  <= '0;
      wr_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      busy_q  <= busy_nxt;
      wr_q    <= clr;
      count_q <= count_nxt;
      err_q   <= err_q | err_hit;
    end
  end

  // Writeback in the same cycle is forwarded, so the source reads as ready.
  assign sb.rs1_busy     = busy_q[sb.rs1] & ~clr[sb.rs1];
  assign sb.rs2_busy     = busy_q[sb.rs2] & ~clr[sb.rs2];
  assign sb.iss_ready    = iss_ready;
  assign sb.wr_onehot    = wr_q;
  assign sb.busy_vec     = busy_q;
  assign sb.busy_count   = count_q;
  assign sb.err_clr_idle = err_q;
endmodule
